bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Sequential round-robin arbiter for the shared 32-bit CPU datapath bus. Up to 24 bus sources request the bus: R0–R15, HI, LO, ZHI, ZLO, PC, MDR, InPort and C. The arbiter grants exactly one requester at a time and drives the 5-bit encoded select into the bus multiplexer. It sits between the control unit's per-source drive requests and the bus mux select input, and guarantees that the bus is never multiply driven.

## Interface
- N_REQ, 24, number of requesters; index i equals the bus mux select code for that source.
- SEL_W, 5, select width; ceil(log2(N_REQ)).
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the bus while others wait (timeout feature only); must be at least 1.

Ports:
- clock, in, 1, sole clock; all state updates on the rising edge.
- clear, in, 1, reset; synchronous and active-high.
- req, in, N_REQ, level request; bit i high means source i wants to drive the bus.
- grant, out, N_REQ, one-hot (or zero) registered grant.
- sel, out, SEL_W, encoded index of the granted source; feeds the bus mux select.
- bus_valid, out, 1, high when grant is non-zero.
- preempt, out, 1, one-cycle pulse in the cycle after an owner is forcibly rotated off the bus (timeout feature only, else tied 0).

## Operation
- Two states:
  - IDLE: no owner.
  - OWNED: one owner, tracked in registered `owner` index plus grant.
- Round-robin pointer `last` (SEL_W bits) holds the most recently granted index. The search order starts at last+1 and wraps from N_REQ-1 to 0. The requester at index `last` has the lowest priority.
- IDLE:
  - If any req bit is set, pick the first set bit in search order, register grant/sel/owner, set last := pick, go to OWNED.
  - Otherwise stay in IDLE.
- OWNED, owner still requesting (req[owner]=1): keep the grant unchanged, except for forced rotation when the timeout feature is compiled in (see Configuration).
- OWNED, owner drops req:
  - If other requests are pending, hand the bus directly to the next pick at the same edge. There is no idle bubble.
  - Otherwise go to IDLE.
- Requests on indices ≥ N_REQ do not exist. sel is never driven to a value ≥ N_REQ.
- A newly rising request never interrupts a current owner, except through timeout.
- Outputs in IDLE: grant = 0, sel = 0, bus_valid = 0. Consumers must qualify sel with bus_valid.

## Timing
- Reset (clear=1 at an edge):
  - Outputs: grant = 0, sel = 0, bus_valid = 0, preempt = 0.
  - Internal: state = IDLE, last = N_REQ-1 (so index 0 wins first), hold_cnt = 0.
  - clear has priority over all other inputs and aborts any ownership in progress.
- Grant latency: a request sampled at edge k produces grant/sel/bus_valid visible after edge k when the bus is free. It is visible after the release edge when the bus is busy.
- Release: the owner deasserting req before edge k loses grant after edge k. A successor's grant appears after that same edge.
- Simultaneous requests: the winner is determined only by the search order from last+1.
- grant and sel change only at clock edges. There are no combinational paths from req to any output.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - hold_cnt counts cycles of continuous ownership, is cleared on each new grant, and saturates at MAX_HOLD-1.
  - When hold_cnt = MAX_HOLD-1, req[owner] is still set and another request is pending, the grant rotates to the next pick at the next edge. preempt pulses for one cycle after that edge.
  - With no other requester pending, the owner keeps the bus indefinitely.
- BUS_ARB_TIMEOUT_EN undefined: no hold counter is present, an owner keeps the bus until it drops req, and preempt is constant 0.

## Structure
- Package bus_arb_pkg:
  - N_REQ and SEL_W localparams.
  - Source index constants: SRC_R0..SRC_R15 = 0..15, SRC_HI = 16, SRC_LO = 17, SRC_ZHI = 18, SRC_ZLO = 19, SRC_PC = 20, SRC_MDR = 21, SRC_INPORT = 22, SRC_C = 23.
  - State enum: IDLE, OWNED.
- Sub-module bus_arb_rr_pick: combinational round-robin picker. Inputs: req vector, last pointer, exclude-index enable. Outputs: pick index and any-valid.
- Top level: state register, owner/last/hold_cnt registers and output registers.

## Test plan
- After reset, single request: req = bit 20 (PC) held → after one edge grant = 1<<20, sel = 20, bus_valid = 1. Drop req → after one edge bus_valid = 0, sel = 0.
- Simultaneous requests from reset: req = bits 3 and 21 (R3, MDR) → grant R3 first. R3 drops → MDR granted at the same edge with no idle cycle. A new R3 request while MDR owns is not granted until MDR releases.
- Fairness: bits 0, 1 and 23 requested, each holding 2 cycles then dropping and re-requesting → grant order 0, 1, 23, 0, 1, 23. The owner index never repeats back-to-back while others wait.
- Timeout (BUS_ARB_TIMEOUT_EN, MAX_HOLD = 8): bit 5 held continuously, bit 16 (HI) raised at cycle 2 → grant moves to 16 after bit 5 has owned for 8 cycles, with preempt = 1 for exactly one cycle. Without the macro, bit 5 keeps the bus indefinitely.
- Mid-operation reset: owner 22 (InPort) granted, clear pulsed for one cycle → grant = 0, sel = 0 after that edge. With req = bits 22 and 0 still asserted, index 0 is granted next.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter: requester count, select width, source codes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package bus_arb_pkg;

    localparam int N_REQ = 24;
    localparam int SEL_W = 5;

    // Source indices double as bus mux select codes
    localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
    localparam logic [SEL_W-1:0] SRC_R1     = 5'd1;
    localparam logic [SEL_W-1:0] SRC_R2     = 5'd2;
    localparam logic [SEL_W-1:0] SRC_R3     = 5'd3;
    localparam logic [SEL_W-1:0] SRC_R4     = 5'd4;
    localparam logic [SEL_W-1:0] SRC_R5     = 5'd5;
    localparam logic [SEL_W-1:0] SRC_R6     = 5'd6;
    localparam logic [SEL_W-1:0] SRC_R7     = 5'd7;
    localparam logic [SEL_W-1:0] SRC_R8     = 5'd8;
    localparam logic [SEL_W-1:0] SRC_R9     = 5'd9;
    localparam logic [SEL_W-1:0] SRC_R10    = 5'd10;
    localparam logic [SEL_W-1:0] SRC_R11    = 5'd11;
    localparam logic [SEL_W-1:0] SRC_R12    = 5'd12;
    localparam logic [SEL_W-1:0] SRC_R13    = 5'd13;
    localparam logic [SEL_W-1:0] SRC_R14    = 5'd14;
    localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
    localparam logic [SEL_W-1:0] SRC_HI     = 5'd16;
    localparam logic [SEL_W-1:0] SRC_LO     = 5'd17;
    localparam logic [SEL_W-1:0] SRC_ZHI    = 5'd18;
    localparam logic [SEL_W-1:0] SRC_ZLO    = 5'd19;
    localparam logic [SEL_W-1:0] SRC_PC     = 5'd20;
    localparam logic [SEL_W-1:0] SRC_MDR    = 5'd21;
    localparam logic [SEL_W-1:0] SRC_INPORT = 5'd22;
    localparam logic [SEL_W-1:0] SRC_C      = 5'd23;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // Index reached by stepping 'off' places past 'base', wrapping at N_REQ
    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base, input int off);
        return SEL_W'((int'(base) + off) % N_REQ);
    endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Round-robin picker: first set request bit in search order last+1 .. last (wrapping).
// Latency: purely combinational.
// Backpressure: none; excl_en drops index 'last' itself from the candidates.
module bus_arb_rr_pick
    import bus_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    input  logic             excl_en,
    output logic [SEL_W-1:0] pick,
    output logic             any_valid
);

    // Walk the search order once; the last step lands on 'last' (lowest priority)
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            if (!any_valid && req[rr_index(last, off)] && !(excl_en && off == N_REQ)) begin
                any_valid = 1'b1;
                pick      = rr_index(last, off);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared datapath bus; registered one-hot grant plus encoded sel.
// Latency: one edge from request to grant on a free bus; handover at the release edge with no bubble.
// Backpressure: an owner holds the bus until it drops req (or, with BUS_ARB_TIMEOUT_EN, until timed out).
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             bus_valid,
    output logic             preempt
);

    state_t           state;
    logic [SEL_W-1:0] owner;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] pick;
    logic             any_valid;

    // MAX_HOLD below 1 is not a meaningful configuration
    if (MAX_HOLD < 1) begin : g_max_hold_invalid
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_cnt;
`endif

    // While owned, the owner (== last) is excluded so a timeout rotates to someone else
    bus_arb_rr_pick u_pick (
        .req       (req),
        .last      (last),
        .excl_en   (state == OWNED),
        .pick      (pick),
        .any_valid (any_valid)
    );

    // Ownership FSM with registered grant/sel/bus_valid/preempt
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= SEL_W'(N_REQ - 1);
            grant     <= '0;
            sel       <= '0;
            bus_valid <= 1'b0;
            preempt   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state     <= OWNED;
                        owner     <= pick;
                        last      <= pick;
                        grant     <= N_REQ'(1) << pick;
                        sel       <= pick;
                        bus_valid <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                OWNED: begin
                    if (!req[owner]) begin
                        if (any_valid) begin
                            owner     <= pick;
                            last      <= pick;
                            grant     <= N_REQ'(1) << pick;
                            sel       <= pick;
`ifdef BUS_ARB_TIMEOUT_EN
                            hold_cnt  <= '0;
`endif
                        end else begin
                            state     <= IDLE;
                            grant     <= '0;
                            sel       <= '0;
                            bus_valid <= 1'b0;
                        end
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (hold_cnt == HOLD_MAX) begin
                        // Saturated: rotate only if someone else is waiting
                        if (any_valid) begin
                            owner    <= pick;
                            last     <= pick;
                            grant    <= N_REQ'(1) << pick;
                            sel      <= pick;
                            hold_cnt <= '0;
                            preempt  <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter with a per-cycle reference model and literal checkpoints.
// Latency: model updates at each rising edge, compare on the falling edge.
// Backpressure: n/a.
module tb_bus_arbiter;

    localparam int NR       = 24;
    localparam int MAX_HOLD = 8;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic [NR-1:0] req   = '0;
    logic [NR-1:0] grant;
    logic [4:0]    sel;
    logic          bus_valid;
    logic          preempt;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clock     (clock),
        .clear     (clear),
        .req       (req),
        .grant     (grant),
        .sel       (sel),
        .bus_valid (bus_valid),
        .preempt   (preempt)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int m_owner = -1;   // -1: bus free
    int m_last  = NR - 1;
    int m_owned = 0;    // cycles the current owner has held the bus
    bit m_pre   = 1'b0;

    function automatic int next_pick(input logic [NR-1:0] r, input int from, input bit skip_from);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (from + k) % NR;
            if (k == NR && skip_from) continue;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clock) begin
        int p;
        m_pre = 1'b0;
        if (clear) begin
            m_owner = -1;
            m_last  = NR - 1;
            m_owned = 0;
        end else if (m_owner < 0) begin
            p = next_pick(req, m_last, 1'b0);
            if (p >= 0) begin
                m_owner = p; m_last = p; m_owned = 1;
            end
        end else if (!req[m_owner]) begin
            p = next_pick(req, m_last, 1'b0);
            m_owner = p;
            if (p >= 0) begin
                m_last = p; m_owned = 1;
            end else begin
                m_owned = 0;
            end
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            p = next_pick(req, m_last, 1'b1);
            if (m_owned >= MAX_HOLD && p >= 0) begin
                m_owner = p; m_last = p; m_owned = 1; m_pre = 1'b1;
            end else if (m_owned < MAX_HOLD) begin
                m_owned = m_owned + 1;
            end
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        logic [NR-1:0] eg;
        logic [4:0]    es;
        if (checking) begin
            eg = (m_owner >= 0) ? (24'd1 << m_owner) : 24'd0;
            es = (m_owner >= 0) ? 5'(m_owner) : 5'd0;
            n_vec++;
            if (grant !== eg)                   begin n_err++; $display("FAIL cyc_grant t=%0t got=%h exp=%h", $time, grant, eg); end
            if (sel !== es)                     begin n_err++; $display("FAIL cyc_sel t=%0t got=%0d exp=%0d", $time, sel, es); end
            if (bus_valid !== (m_owner >= 0))   begin n_err++; $display("FAIL cyc_valid t=%0t got=%b exp=%b", $time, bus_valid, m_owner >= 0); end
            if (preempt !== m_pre)              begin n_err++; $display("FAIL cyc_preempt t=%0t got=%b exp=%b", $time, preempt, m_pre); end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic [NR-1:0] r, input logic c);
        req   = r;
        clear = c;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Literal checkpoint: DUT and model both pinned to a hand-computed owner (-1 = idle)
    task automatic chk(input string name, input int exp_owner, input logic exp_pre);
        logic [NR-1:0] eg;
        logic [4:0]    es;
        #2;
        eg = (exp_owner >= 0) ? (24'd1 << exp_owner) : 24'd0;
        es = (exp_owner >= 0) ? 5'(exp_owner) : 5'd0;
        n_vec++;
        if (grant !== eg || sel !== es || bus_valid !== (exp_owner >= 0) || preempt !== exp_pre) begin
            n_err++;
            $display("FAIL %s dut grant=%h sel=%0d vld=%b pre=%b exp grant=%h sel=%0d vld=%b pre=%b",
                     name, grant, sel, bus_valid, preempt, eg, es, exp_owner >= 0, exp_pre);
        end
        n_vec++;
        if (m_owner != exp_owner || m_pre != exp_pre) begin
            n_err++;
            $display("FAIL %s_model owner=%0d pre=%b exp owner=%0d pre=%b", name, m_owner, m_pre, exp_owner, exp_pre);
        end
    endtask

    task automatic do_reset();
        cyc('0, 1'b1);
        cyc('0, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    int order [6] = '{0, 1, 23, 0, 1, 23};

    initial begin
        logic [NR-1:0] all3;
        all3 = (24'd1 << 0) | (24'd1 << 1) | (24'd1 << 23);

        do_reset();
        checking = 1'b1;
        chk("reset", -1, 1'b0);

        // Single requester PC
        cyc(24'd1 << 20, 1'b0);           chk("pc_grant", 20, 1'b0);
        cyc(24'd1 << 20, 1'b0);           chk("pc_hold", 20, 1'b0);
        cyc('0, 1'b0);                    chk("pc_release", -1, 1'b0);

        // R3 and MDR together from reset
        do_reset();
        cyc((24'd1 << 3) | (24'd1 << 21), 1'b0); chk("r3_first", 3, 1'b0);
        cyc((24'd1 << 3) | (24'd1 << 21), 1'b0); chk("r3_hold", 3, 1'b0);
        cyc(24'd1 << 21, 1'b0);                  chk("mdr_handover", 21, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc((24'd1 << 3) | (24'd1 << 21), 1'b0);
            chk("mdr_keeps", 21, 1'b0);
        end
        cyc(24'd1 << 3, 1'b0);                   chk("r3_after_mdr", 3, 1'b0);
        cyc('0, 1'b0);                           chk("idle_again", -1, 1'b0);

        // Fairness among 0, 1, 23
        do_reset();
        cyc(all3, 1'b0);
        for (int j = 0; j < 6; j++) begin
            chk("fair_grant", order[j], 1'b0);
            cyc(all3, 1'b0);
            chk("fair_hold", order[j], 1'b0);
            cyc(all3 & ~(24'd1 << order[j]), 1'b0);
        end
        cyc('0, 1'b0);

        // Long hold by R5 with HI waiting
        do_reset();
        cyc(24'd1 << 5, 1'b0);            chk("r5_grant", 5, 1'b0);
        cyc(24'd1 << 5, 1'b0);            chk("r5_c1", 5, 1'b0);
        for (int k = 2; k < 8; k++) begin
            cyc((24'd1 << 5) | (24'd1 << 16), 1'b0);
            chk("r5_owns", 5, 1'b0);
        end
        cyc((24'd1 << 5) | (24'd1 << 16), 1'b0);
`ifdef BUS_ARB_TIMEOUT_EN
        chk("timeout_rotate", 16, 1'b1);
        cyc((24'd1 << 5) | (24'd1 << 16), 1'b0);
        chk("preempt_one_cycle", 16, 1'b0);
`else
        chk("no_timeout", 5, 1'b0);
        for (int k = 0; k < 20; k++) cyc((24'd1 << 5) | (24'd1 << 16), 1'b0);
        chk("no_timeout_long", 5, 1'b0);
`endif
        cyc('0, 1'b0);
        cyc('0, 1'b0);

        // Mid-operation reset while InPort owns
        do_reset();
        cyc(24'd1 << 22, 1'b0);                   chk("inport_grant", 22, 1'b0);
        cyc((24'd1 << 22) | 24'd1, 1'b1);         chk("mid_clear", -1, 1'b0);
        cyc((24'd1 << 22) | 24'd1, 1'b0);         chk("r0_after_clear", 0, 1'b0);
        cyc('0, 1'b0);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
